// File: rtl/pc_unit.sv
// Program-counter unit: selects next PC from sequential/branch/jump/return paths,
// with stall, a circular return-address stack, and misalignment/underflow pulses.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic             jump,
  input  logic [WIDTH-1:0] jumpTarget,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcPlus,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             misaligned,
  output logic             retUnderflow
);

  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] ras_q [0:RAS_DEPTH-1];

  logic             push_en;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] top_pop;
  logic [CNT_W-1:0] count_pop;
  logic [WIDTH-1:0] sel_target;
  logic             redirect;

  assign pcPlus       = pc_q + INC_W;
  assign pc           = pc_q;
  assign rasEmpty     = (count_q == '0);
  assign rasFull      = (count_q == CNT_MAX);
  assign misaligned   = misaligned_q;
  assign retUnderflow = underflow_q;

  always_comb begin
    pc_d         = pc_q;
    top_d        = top_q;
    count_d      = count_q;
    misaligned_d = 1'b0;
    underflow_d  = 1'b0;
    push_en      = 1'b0;
    push_idx     = top_q;
    top_pop      = top_q;
    count_pop    = count_q;
    sel_target   = pcPlus;
    redirect     = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (rasEmpty) begin
          underflow_d = 1'b1;
        end else begin
          sel_target = ras_q[top_q];
          redirect   = 1'b1;
          top_pop    = top_q - PTR_W'(1);
          count_pop  = count_q - CNT_W'(1);
        end
      end else if (jump) begin
        sel_target = jumpTarget;
        redirect   = 1'b1;
      end else if (branchTaken) begin
        sel_target = branchTarget;
        redirect   = 1'b1;
      end

      if (redirect && ((sel_target & ALIGN_MASK) != '0)) begin
        misaligned_d = 1'b1;
        pc_d         = pcPlus;
      end else begin
        pc_d = sel_target;
      end

      // Pop (if any) is applied before the push, so ret+jump+call rewrites the top slot.
      top_d   = top_pop;
      count_d = count_pop;
      if (jump && call) begin
        push_en  = 1'b1;
        push_idx = top_pop + PTR_W'(1);
        top_d    = push_idx;
        count_d  = (count_pop == CNT_MAX) ? count_pop : count_pop + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      top_q        <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      top_q        <= top_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      underflow_q  <= underflow_d;
    end
  end

  // Stack storage has no reset; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      ras_q[push_idx] <= pcPlus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: default 32-bit instance plus an 8-bit wrap instance.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branchTaken, jump, call, ret;
  logic [31:0] branchTarget, jumpTarget;
  logic [31:0] pc, pcPlus;
  logic        rasEmpty, rasFull, misaligned, retUnderflow;

  logic        reset2;
  logic [7:0]  pc2, pcPlus2;
  logic        rasEmpty2, rasFull2, misaligned2, retUnderflow2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .call(call), .ret(ret),
    .pc(pc), .pcPlus(pcPlus), .rasEmpty(rasEmpty), .rasFull(rasFull),
    .misaligned(misaligned), .retUnderflow(retUnderflow)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hFC), .INC(4), .RAS_DEPTH(4)) dut_w8 (
    .clk(clk), .reset(reset2), .stall(1'b0),
    .branchTaken(1'b0), .branchTarget(8'h00),
    .jump(1'b0), .jumpTarget(8'h00), .call(1'b0), .ret(1'b0),
    .pc(pc2), .pcPlus(pcPlus2), .rasEmpty(rasEmpty2), .rasFull(rasFull2),
    .misaligned(misaligned2), .retUnderflow(retUnderflow2)
  );

  task automatic idle();
    stall = 0; branchTaken = 0; jump = 0; call = 0; ret = 0;
    branchTarget = '0; jumpTarget = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    step(); step();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    n_checks++; if (pcPlus !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus got %h want %h", pcPlus, 32'h4); end
    n_checks++; if ({rasEmpty, rasFull, misaligned, retUnderflow} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got %b want %b", {rasEmpty, rasFull, misaligned, retUnderflow}, 4'b1000); end
    reset = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 32'(4 * i)); end
    end
    $display("test_reset: pc=%h", pc);
  endtask

  task automatic test_stall_priority();
    stall = 1; jump = 1; jumpTarget = 32'h80; branchTaken = 1; branchTarget = 32'h40;
    step();
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL stall1_pc got %h want %h", pc, 32'h10); end
    step();
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL stall2_pc got %h want %h", pc, 32'h10); end
    stall = 0;
    step();
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL jump_over_branch got %h want %h", pc, 32'h80); end
    idle(); branchTaken = 1; branchTarget = 32'h40;
    step();
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL branch_only got %h want %h", pc, 32'h40); end
    idle();
    $display("test_stall_priority: pc=%h", pc);
  endtask

  task automatic test_call_return();
    jump = 1; jumpTarget = 32'h100;
    step();
    n_checks++; if (pc !== 32'h100 || rasEmpty !== 1'b1) begin n_fail++; $display("FAIL plain_jump got pc=%h empty=%b want 100/1", pc, rasEmpty); end
    call = 1; jumpTarget = 32'h200;
    step();
    n_checks++; if (pc !== 32'h200 || rasEmpty !== 1'b0) begin n_fail++; $display("FAIL call1 got pc=%h empty=%b want 200/0", pc, rasEmpty); end
    jumpTarget = 32'h300;
    step();
    n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL call2 got %h want %h", pc, 32'h300); end
    idle(); ret = 1;
    step();
    n_checks++; if (pc !== 32'h204) begin n_fail++; $display("FAIL ret1 got %h want %h", pc, 32'h204); end
    step();
    n_checks++; if (pc !== 32'h104 || rasEmpty !== 1'b1 || retUnderflow !== 1'b0) begin
      n_fail++; $display("FAIL ret2 got pc=%h empty=%b und=%b want 104/1/0", pc, rasEmpty, retUnderflow); end
    idle();
    $display("test_call_return: pc=%h", pc);
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h4004; exp_ret[1] = 32'h3004; exp_ret[2] = 32'h2004; exp_ret[3] = 32'h1004;
    jump = 1; call = 1;
    for (int i = 1; i <= 5; i++) begin
      jumpTarget = 32'(i * 32'h1000);
      step();
      n_checks++; if (pc !== 32'(i * 32'h1000)) begin n_fail++; $display("FAIL ovf_call[%0d] got %h want %h", i, pc, 32'(i * 32'h1000)); end
    end
    n_checks++; if (rasFull !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", rasFull); end
    idle(); ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret[%0d] got %h want %h", i, pc, exp_ret[i]); end
    end
    n_checks++; if (rasEmpty !== 1'b1 || rasFull !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got empty=%b full=%b want 1/0", rasEmpty, rasFull); end
    step();
    n_checks++; if (pc !== 32'h1008 || retUnderflow !== 1'b1) begin
      n_fail++; $display("FAIL underflow got pc=%h und=%b want 1008/1", pc, retUnderflow); end
    idle();
    step();
    n_checks++; if (pc !== 32'h100C || retUnderflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear got pc=%h und=%b want 100c/0", pc, retUnderflow); end
    $display("test_ras_overflow: pc=%h", pc);
  endtask

  task automatic test_misalign();
    jump = 1; jumpTarget = 32'h20;
    step();
    n_checks++; if (pc !== 32'h20 || misaligned !== 1'b0) begin n_fail++; $display("FAIL align_jump got pc=%h mis=%b want 20/0", pc, misaligned); end
    jumpTarget = 32'h42;
    step();
    n_checks++; if (pc !== 32'h24 || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_jump got pc=%h mis=%b want 24/1", pc, misaligned); end
    idle();
    step();
    n_checks++; if (pc !== 32'h28 || misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear got pc=%h mis=%b want 28/0", pc, misaligned); end
    branchTaken = 1; branchTarget = 32'h41;
    step();
    n_checks++; if (pc !== 32'h2C || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_branch got pc=%h mis=%b want 2c/1", pc, misaligned); end
    idle(); ret = 1; jump = 1; call = 1; jumpTarget = 32'h300;
    step();
    n_checks++; if (pc !== 32'h30 || retUnderflow !== 1'b1 || rasEmpty !== 1'b0) begin
      n_fail++; $display("FAIL combo_empty got pc=%h und=%b empty=%b want 30/1/0", pc, retUnderflow, rasEmpty); end
    idle(); ret = 1;
    step();
    n_checks++; if (pc !== 32'h30 || rasEmpty !== 1'b1 || retUnderflow !== 1'b0) begin
      n_fail++; $display("FAIL combo_pop got pc=%h empty=%b und=%b want 30/1/0", pc, rasEmpty, retUnderflow); end
    idle();
    $display("test_misalign: pc=%h", pc);
  endtask

  task automatic test_reset_midop();
    jump = 1; call = 1; jumpTarget = 32'h400;
    step();
    jumpTarget = 32'h500;
    step();
    n_checks++; if (pc !== 32'h500 || rasEmpty !== 1'b0) begin n_fail++; $display("FAIL midop_setup got pc=%h empty=%b want 500/0", pc, rasEmpty); end
    ret = 1; reset = 1;
    step();
    n_checks++; if (pc !== 32'h0 || rasEmpty !== 1'b1 || misaligned !== 1'b0 || retUnderflow !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset got pc=%h empty=%b mis=%b und=%b want 0/1/0/0", pc, rasEmpty, misaligned, retUnderflow); end
    reset = 0; idle();
    $display("test_reset_midop: pc=%h", pc);
  endtask

  task automatic test_wrap();
    reset2 = 1;
    step();
    n_checks++; if (pc2 !== 8'hFC || pcPlus2 !== 8'h00) begin n_fail++; $display("FAIL wrap_reset got pc=%h plus=%h want fc/00", pc2, pcPlus2); end
    reset2 = 0;
    step();
    n_checks++; if (pc2 !== 8'h00) begin n_fail++; $display("FAIL wrap_pc got %h want %h", pc2, 8'h00); end
    step();
    n_checks++; if (pc2 !== 8'h04) begin n_fail++; $display("FAIL wrap_next got %h want %h", pc2, 8'h04); end
    $display("test_wrap: pc2=%h", pc2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; reset2 = 1; idle();
    test_reset();
    test_stall_priority();
    test_call_return();
    test_ras_overflow();
    test_misalign();
    test_reset_midop();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, successor to the plain PC register. Sits at the head of the fetch stage and owns PC state. Selects the next PC from sequential increment, branch target, jump target or return address, with stall support. Contains a small circular return-address stack (RAS) for call/return prediction and flags misaligned redirects.

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential increment in bytes (power of two, >= 1)
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
stall  input  1  hold PC and RAS this cycle
branchTaken  input  1  redirect to branchTarget
branchTarget  input  WIDTH  branch destination
jump  input  1  redirect to jumpTarget
jumpTarget  input  WIDTH  jump destination
call  input  1  with jump: push pc+INC onto RAS
ret  input  1  redirect to top of RAS and pop
pc  output  WIDTH  current PC (registered)
pcPlus  output  WIDTH  pc+INC (combinational)
rasEmpty  output  1  RAS holds 0 entries
rasFull  output  1  RAS holds RAS_DEPTH entries
misaligned  output  1  registered 1-cycle pulse, rejected redirect
retUnderflow  output  1  registered 1-cycle pulse, ret with empty RAS

Behaviour:
- Reset (sampled at clk edge, overrides everything): pc=RESET_VECTOR, RAS count=0, top pointer=0, misaligned=0, retUnderflow=0. RAS contents are don't-care.
- Latency: next-PC select is combinational. pc updates on the next rising edge. pcPlus = pc+INC, modulo 2^WIDTH. The wrap from all-ones to 0 is legal and silent.
- Priority when not stalled, highest first: ret > jump > branchTaken > sequential (pc+INC).
- stall=1: pc, RAS and count hold. All other inputs are ignored. Pulse outputs go to 0 on the next edge.
- Alignment: a target is misaligned if any of its low log2(INC) bits is nonzero. Applies to branchTarget, jumpTarget and the popped RAS value.
- Misaligned selected target: pc takes pc+INC, misaligned=1 for one cycle. A RAS push/pop on that cycle still occurs.
- jump=1 & call=1: push pcPlus, then load jumpTarget.
  - Push writes at top+1 (mod RAS_DEPTH) and sets top to that slot.
  - count saturates at RAS_DEPTH. Pushing when full overwrites the oldest entry (circular, no error).
- call without jump: ignored.
- ret=1, RAS non-empty: pc=entry[top], top decrements (mod RAS_DEPTH), count decrements.
- ret=1, RAS empty: pc=pc+INC, retUnderflow=1 for one cycle, RAS unchanged.
- ret=1 & jump=1 & call=1 in the same cycle: ret wins the PC. The RAS performs the pop first, then the push of pcPlus. Net effect: count unchanged, entry[top] replaced by pcPlus. Applies on an empty RAS too: count becomes 1, retUnderflow=1.
- rasEmpty = (count==0), rasFull = (count==RAS_DEPTH), both derived from registered count.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge.

Test Plan:
- Reset and sequential run: reset 2 cycles, then 4 idle cycles -> pc 0x0,0x4,0x8,0xC,0x10; rasEmpty=1, outputs 0 during reset.
- Stall and priority: at pc=0x10, stall 2 cycles -> pc holds 0x10. Then branchTaken=1 target 0x40 with jump=1 target 0x80 -> pc=0x80. Then branch only, target 0x40 -> pc=0x40.
- Call/return nesting: from pc=0x100, calls to 0x200 then 0x300, then 2 rets -> pc 0x200, 0x300, 0x204, 0x104; rasEmpty=1 at end.
- RAS overflow, RAS_DEPTH=4: 5 calls from pcs A..E -> rasFull=1. Then 4 rets return E+4, D+4, C+4, B+4. A 5th ret -> retUnderflow pulse, pc=pc+4.
- Misalignment and wrap: jumpTarget=0x42 at pc=0x20 -> pc=0x24, misaligned=1 one cycle. Separately, with WIDTH=8, RESET_VECTOR=8'hFC -> pc 0xFC then 0x00.
- Reset mid-operation: reset asserted together with ret, jump and call with the RAS holding 2 entries -> pc=RESET_VECTOR, rasEmpty=1, no pulse outputs.
